// File: rtl/mem_arbiter_nport_if.sv
// mem_arbiter_nport_if: requester-side and physical-memory-side signal bundle.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_arbiter_nport_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256
);
    logic [NUM_PORTS-1:0]        req_read;
    logic [NUM_PORTS-1:0]        req_write;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_resp;
    logic [DATA_W-1:0]           req_rdata;
    logic                        pmem_read;
    logic                        pmem_write;
    logic [ADDR_W-1:0]           pmem_address;
    logic [DATA_W-1:0]           pmem_wdata;
    logic                        pmem_resp;
    logic [DATA_W-1:0]           pmem_rdata;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, pmem_resp, pmem_rdata,
        output req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, pmem_resp, pmem_rdata,
        input  req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter_nport.sv
// mem_arbiter_nport: arbitrates NUM_PORTS requesters onto one shared memory port,
// one outstanding transaction at a time, fixed-priority or round-robin.
module mem_arbiter_nport #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int RR_MODE   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    mem_arbiter_nport_if.slave           bus,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id_o,
    output logic                         busy_o
);
    localparam int IDW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic                 rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [IDW-1:0]       grant_q, grant_d, ptr_q, ptr_d, win;
    logic [NUM_PORTS-1:0] pending;
    logic                 found;
    int                   idx;

    assign pending = bus.req_read | bus.req_write;

    // Scan starts at the rotating pointer in round-robin mode, at port 0 otherwise.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (RR_MODE != 0) ? (int'(ptr_q) + k) % NUM_PORTS : k;
            if (!found && pending[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE && found) begin
            state_d = BUSY;
            wr_d    = bus.req_write[win];
            rd_d    = ~bus.req_write[win];
            addr_d  = bus.req_addr[win*ADDR_W +: ADDR_W];
            wdata_d = bus.req_wdata[win*DATA_W +: DATA_W];
            grant_d = win;
            ptr_d   = (win == IDW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        end else if (state_q == BUSY && bus.pmem_resp) begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Completion is passed straight through in the cycle memory responds.
    assign bus.req_resp     = (state_q == BUSY && bus.pmem_resp) ? NUM_PORTS'(1) << grant_q : '0;
    assign bus.req_rdata    = bus.pmem_rdata;
    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign grant_id_o       = grant_q;
    assign busy_o           = (state_q == BUSY);
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// tb_mem_arbiter_nport: scoreboard bench; instance 0 is round-robin, instance 1 fixed
// priority, both NUM_PORTS=4, driven with identical directed request streams.
module tb_mem_arbiter_nport;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]    port;
        logic          wr;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stray = 1'b0;
    int   checks = 0;
    int   failures = 0;

    req_t          pq[2*NP][$];
    exp_t          eq[2][$];
    logic [AW-1:0] scr[2*NP];
    logic          msk[2*NP];

    logic          busy_w[2];
    logic [1:0]    gid_w[2];
    logic          prd_w[2];
    logic          pwr_w[2];
    logic [AW-1:0] pad_w[2];
    logic [NP-1:0] rsp_w[2];

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] wd(logic [AW-1:0] a);
        return {a ^ 32'h5a5a5a5a, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        mem_arbiter_nport_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [1:0] gid;
        logic       bsy;

        mem_arbiter_nport #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(g == 0 ? 1 : 0)) dut (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .bus       (bus),
            .grant_id_o(gid),
            .busy_o    (bsy)
        );

        assign busy_w[g] = bsy;
        assign gid_w[g]  = gid;
        assign prd_w[g]  = bus.pmem_read;
        assign pwr_w[g]  = bus.pmem_write;
        assign pad_w[g]  = bus.pmem_address;
        assign rsp_w[g]  = bus.req_resp;

        // Requesters pop on the edge after their resp; memory answers 3 cycles after a request.
        initial begin : drv
            req_t          r;
            int            cnt;
            logic [NP-1:0] last;
            cnt = 0;
            last = '0;
            bus.req_read = '0;
            bus.req_write = '0;
            bus.req_addr = '0;
            bus.req_wdata = '0;
            bus.pmem_resp = 1'b0;
            bus.pmem_rdata = '0;
            forever begin
                @(posedge clk);
                #1;
                bus.pmem_resp = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    if (last[i] && pq[g*NP+i].size() > 0) void'(pq[g*NP+i].pop_front());
                    if (pq[g*NP+i].size() > 0) r = pq[g*NP+i][0];
                    else r = '0;
                    bus.req_read[i] = r.rd & ~msk[g*NP+i];
                    bus.req_write[i] = r.wr & ~msk[g*NP+i];
                    bus.req_addr[i*AW +: AW] = r.addr ^ scr[g*NP+i];
                    bus.req_wdata[i*DW +: DW] = r.wdata;
                end
                if (!rst_n) cnt = 0;
                else if (bus.pmem_read || bus.pmem_write) begin
                    cnt++;
                    if (cnt == 3) begin
                        cnt = 0;
                        bus.pmem_resp = 1'b1;
                        bus.pmem_rdata = {bus.pmem_address, ~bus.pmem_address};
                    end
                end else if (stray) begin
                    bus.pmem_resp = 1'b1;
                    bus.pmem_rdata = '1;
                end
                #1 last = bus.req_resp;
            end
        end

        initial begin : mon
            exp_t e;
            forever begin
                @(posedge clk);
                #2;
                if (bus.req_resp != '0) begin
                    if (eq[g].size() == 0) chk($sformatf("g%0d_unexpected_resp", g), bus.req_resp, 0);
                    else begin
                        e = eq[g].pop_front();
                        chk($sformatf("g%0d_resp", g), bus.req_resp, 4'b0001 << e.port);
                        chk($sformatf("g%0d_grant", g), gid, e.port);
                        chk($sformatf("g%0d_op", g), {bus.pmem_read, bus.pmem_write}, {~e.wr, e.wr});
                        chk($sformatf("g%0d_addr", g), bus.pmem_address, e.addr);
                        chk($sformatf("g%0d_rdata", g), bus.req_rdata, {e.addr, ~e.addr});
                        if (e.wr) chk($sformatf("g%0d_wdata", g), bus.pmem_wdata, wd(e.addr));
                    end
                end
            end
        end
    end

    task automatic issue(int p, bit rd, bit wr, logic [AW-1:0] a);
        req_t r;
        r.rd = rd;
        r.wr = wr;
        r.addr = a;
        r.wdata = wr ? wd(a) : '0;
        pq[p].push_back(r);
        pq[NP+p].push_back(r);
    endtask

    task automatic ex(int g, int p, bit wr, logic [AW-1:0] a);
        exp_t e;
        e.port = 2'(p);
        e.wr = wr;
        e.addr = a;
        eq[g].push_back(e);
    endtask

    task automatic wait_idle(string n);
        bit done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #3;
            done = eq[0].size() == 0 && eq[1].size() == 0 && !busy_w[0] && !busy_w[1];
            for (int i = 0; i < 2*NP; i++) if (pq[i].size() != 0) done = 1'b0;
        end
        chk({n, "_done"}, done, 1);
    endtask

    initial begin
        for (int i = 0; i < 2*NP; i++) begin
            scr[i] = '0;
            msk[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_rst_busy", g), busy_w[g], 0);
            chk($sformatf("g%0d_rst_rw", g), {prd_w[g], pwr_w[g]}, 0);
            chk($sformatf("g%0d_rst_addr", g), pad_w[g], 0);
            chk($sformatf("g%0d_rst_gid", g), gid_w[g], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #3;

        // All four ports keep two reads queued each.
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) issue(p, 1, 0, 32'h1000 + p*256 + k*16);
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) ex(0, p, 0, 32'h1000 + p*256 + k*16);
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 2; k++) ex(1, p, 0, 32'h1000 + p*256 + k*16);
        wait_idle("all_ports");

        // Port 0 read (address wiggled mid-transaction) followed by port 2 write (dropped mid-transaction).
        issue(0, 1, 0, 32'h4000);
        issue(2, 0, 1, 32'h4200);
        for (int g = 0; g < 2; g++) begin
            ex(g, 0, 0, 32'h4000);
            ex(g, 2, 1, 32'h4200);
        end
        repeat (3) @(posedge clk);
        #3;
        scr[0] = 32'hffff0000;
        scr[NP] = 32'hffff0000;
        repeat (2) @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) chk($sformatf("g%0d_addr_hold", g), pad_w[g], 32'h4000);
        repeat (3) @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_p2_rw", g), {prd_w[g], pwr_w[g]}, 2'b01);
            chk($sformatf("g%0d_p2_gid", g), gid_w[g], 2);
        end
        msk[2] = 1'b1;
        msk[NP+2] = 1'b1;
        wait_idle("hold_drop");
        for (int i = 0; i < 2*NP; i++) begin
            scr[i] = '0;
            msk[i] = 1'b0;
        end

        // Single read on port 1: one cycle from request to pmem_read.
        issue(1, 1, 0, 32'h0000_1234);
        for (int g = 0; g < 2; g++) ex(g, 1, 0, 32'h0000_1234);
        @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) chk($sformatf("g%0d_lat0", g), prd_w[g], 0);
        @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_lat1", g), {prd_w[g], busy_w[g]}, 2'b11);
            chk($sformatf("g%0d_lat1_addr", g), pad_w[g], 32'h0000_1234);
        end
        wait_idle("single");

        // Read and write both set: write wins.
        issue(1, 1, 1, 32'h5500);
        for (int g = 0; g < 2; g++) ex(g, 1, 1, 32'h5500);
        wait_idle("rdwr");

        // Memory response while idle must not produce a completion.
        stray = 1'b1;
        @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) chk($sformatf("g%0d_stray", g), {rsp_w[g], busy_w[g]}, 0);
        stray = 1'b0;

        // Reset mid-transaction aborts; afterwards pointer restarts at port 0.
        issue(1, 1, 0, 32'h6100);
        repeat (3) @(posedge clk);
        #3;
        for (int g = 0; g < 2; g++) chk($sformatf("g%0d_pre_rst_busy", g), busy_w[g], 1);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_abort", g), {prd_w[g], busy_w[g], gid_w[g]}, 0);
            chk($sformatf("g%0d_abort_addr", g), pad_w[g], 0);
        end
        for (int i = 0; i < 2*NP; i++) pq[i].delete();
        eq[0].delete();
        eq[1].delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        issue(3, 1, 0, 32'h6300);
        issue(0, 1, 0, 32'h6000);
        for (int g = 0; g < 2; g++) begin
            ex(g, 0, 0, 32'h6000);
            ex(g, 3, 0, 32'h6300);
        end
        wait_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
